// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK demodulation controller.
// Holds the FSM encodings, the default widths and the sync pattern.
package fsk_pkg;

    localparam int DW = 21;
    localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DIFF  = 2'd3
    } samp_state_e;

    typedef enum logic {
        F_SEARCH = 1'b0,
        F_LOCKED = 1'b1
    } frame_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fsk_frame_sync.sv
// Frame synchroniser: hunts for the sync word in the decided bit stream,
// then holds locked for a fixed number of payload bits.
module fsk_frame_sync #(
    parameter logic [15:0] SYNC_WORD  = fsk_pkg::SYNC_WORD_DEF,
    parameter int          FRAME_BITS = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_i,
    input  logic bit_vld_i,
    output logic frame_start_o,
    output logic locked_o
);
    import fsk_pkg::*;

    localparam int FCW = clog2(FRAME_BITS + 1);

    frame_state_e   state_q;
    logic [15:0]    sr_q;
    logic [FCW-1:0] cnt_q;
    logic           locked_q;
    logic [15:0]    sr_d;
    logic           match;

    // The match looks at the register as it will be after this bit shifts in,
    // so frame_start lines up with the bit_vld of the last sync bit.
    assign sr_d  = {sr_q[14:0], bit_i};
    assign match = bit_vld_i && (state_q == F_SEARCH) && (sr_d == SYNC_WORD);

    assign frame_start_o = match;
    assign locked_o      = locked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= F_SEARCH;
            sr_q     <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                F_SEARCH: begin
                    if (bit_vld_i) begin
                        sr_q <= sr_d;
                        if (match) begin
                            locked_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= F_LOCKED;
                        end
                    end
                end
                F_LOCKED: begin
                    if (bit_vld_i) begin
                        if (cnt_q == FCW'(FRAME_BITS - 1)) begin
                            locked_q <= 1'b0;
                            sr_q     <= '0;
                            state_q  <= F_SEARCH;
                        end else begin
                            cnt_q <= cnt_q + FCW'(1);
                        end
                    end
                end
                default: state_q <= F_SEARCH;
            endcase
        end
    end

endmodule

// File: rtl/fsk_demod_ctrl.sv
// FSK demodulation sequencer: feeds samples to the shared phase engine,
// differentiates the phase, integrates over a symbol and frames the bits.
module fsk_demod_ctrl #(
    parameter int          DW         = fsk_pkg::DW,
    parameter int          SPS        = 8,
    parameter logic [15:0] SYNC_WORD  = fsk_pkg::SYNC_WORD_DEF,
    parameter int          FRAME_BITS = 64,
    parameter int          TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_vld,
    input  logic signed [DW-1:0] Ic,
    input  logic signed [DW-1:0] Qc,
    output logic                 cordic_start,
    output logic signed [DW-1:0] cordic_x,
    output logic signed [DW-1:0] cordic_y,
    input  logic                 cordic_done,
    input  logic signed [DW-1:0] cordic_phase,
    output logic signed [DW-1:0] freq_out,
    output logic                 freq_vld,
    output logic                 bit_out,
    output logic                 bit_vld,
    output logic                 frame_start,
    output logic                 locked,
    output logic                 overrun,
    output logic                 timeout_err
);
    import fsk_pkg::*;

    localparam int CW  = clog2(SPS);
    localparam int AW  = DW + CW;
    localparam int WDW = clog2(TIMEOUT + 1);

    samp_state_e    state_q;
    logic [DW-1:0]  x_q, y_q, phase_q, prev_q, freq_q;
    logic [AW-1:0]  acc_q;
    logic [CW-1:0]  scnt_q;
    logic [WDW-1:0] wd_q;
    logic           first_q, start_q, fvld_q, ovr_q, tmo_q;
    logic           sym_done_q, sym_bit_q, bit_q, bvld_q;

    logic [DW-1:0]  freq_d;
    logic [AW-1:0]  acc_d;

    // Modular subtraction is the phase unwrap: a jump across +-pi wraps back.
    assign freq_d = phase_q - prev_q;
    assign acc_d  = acc_q + {{(AW-DW){freq_d[DW-1]}}, freq_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            phase_q    <= '0;
            prev_q     <= '0;
            freq_q     <= '0;
            acc_q      <= '0;
            scnt_q     <= '0;
            wd_q       <= '0;
            first_q    <= 1'b1;
            start_q    <= 1'b0;
            fvld_q     <= 1'b0;
            ovr_q      <= 1'b0;
            tmo_q      <= 1'b0;
            sym_done_q <= 1'b0;
            sym_bit_q  <= 1'b0;
            bit_q      <= 1'b0;
            bvld_q     <= 1'b0;
        end else begin
            start_q    <= 1'b0;
            fvld_q     <= 1'b0;
            ovr_q      <= sample_vld && (state_q != S_IDLE);
            tmo_q      <= 1'b0;
            sym_done_q <= 1'b0;
            // Decision is staged one cycle so bit_vld trails freq_vld.
            bvld_q     <= sym_done_q;
            if (sym_done_q) bit_q <= sym_bit_q;

            case (state_q)
                S_IDLE: begin
                    if (sample_vld) begin
                        x_q     <= Ic;
                        y_q     <= Qc;
                        start_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cordic_done) begin
                        phase_q <= cordic_phase;
                        state_q <= S_DIFF;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        tmo_q   <= 1'b1;
                        first_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                S_DIFF: begin
                    prev_q  <= phase_q;
                    state_q <= S_IDLE;
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else begin
                        freq_q <= freq_d;
                        fvld_q <= 1'b1;
                        if (scnt_q == CW'(SPS - 1)) begin
                            sym_done_q <= 1'b1;
                            sym_bit_q  <= ~acc_d[AW-1];
                            acc_q      <= '0;
                            scnt_q     <= '0;
                        end else begin
                            acc_q  <= acc_d;
                            scnt_q <= scnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    fsk_frame_sync #(
        .SYNC_WORD  (SYNC_WORD),
        .FRAME_BITS (FRAME_BITS)
    ) u_frame_sync (
        .clk           (clk),
        .rst_n         (rst_n),
        .bit_i         (bit_q),
        .bit_vld_i     (bvld_q),
        .frame_start_o (frame_start),
        .locked_o      (locked)
    );

    assign cordic_start = start_q;
    assign cordic_x     = x_q;
    assign cordic_y     = y_q;
    assign freq_out     = freq_q;
    assign freq_vld     = fvld_q;
    assign bit_out      = bit_q;
    assign bit_vld      = bvld_q;
    assign overrun      = ovr_q;
    assign timeout_err  = tmo_q;

endmodule
